// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter: FSM states, grant owner, default widths.
package mem_port_arbiter_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_DM = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_DM   = 2'd2
  } grant_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch requester, data requester, unified memory and hazard signals around the arbiter.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic          if_ack_o;
  logic [DW-1:0] if_rdata_o;
  logic          dm_req_i;
  logic          dm_we_i;
  logic [AW-1:0] dm_addr_i;
  logic [DW-1:0] dm_wdata_i;
  logic          dm_ack_o;
  logic [DW-1:0] dm_rdata_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_ack_i;
  logic [DW-1:0] mem_rdata_i;
  logic          stall_o;
  logic          proto_err_o;

  // arbiter side
  modport slave (
    input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    input  mem_ack_i, mem_rdata_i,
    output if_ack_o, if_rdata_o, dm_ack_o, dm_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o, proto_err_o
  );

  // pipeline requesters plus memory
  modport master (
    output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    output mem_ack_i, mem_rdata_i,
    input  if_ack_o, if_rdata_o, dm_ack_o, dm_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o, proto_err_o
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and data access.
// Data wins ties; a saturating streak counter forces a fetch grant after FETCH_STARVE_MAX data grants.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW               = AW_DEF,
  parameter int DW               = DW_DEF,
  parameter int FETCH_STARVE_MAX = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  mem_port_arbiter_if.slave   bus
);

  localparam int             SW         = $clog2(FETCH_STARVE_MAX + 1);
  localparam logic [SW-1:0]  STREAK_MAX = SW'(FETCH_STARVE_MAX);
  localparam logic [SW-1:0]  STREAK_ONE = SW'(1);

  state_e        state_r;
  grant_e        grant_r;
  logic [SW-1:0] streak_r;
  logic          mem_req_r;
  logic          mem_we_r;
  logic [AW-1:0] mem_addr_r;
  logic [DW-1:0] mem_wdata_r;
  logic          proto_err_r;
  grant_e        pick_s;
  logic          if_ack_s;
  logic          dm_ack_s;

  // Data first unless fetch is waiting and has already been passed over STREAK_MAX times.
  function automatic grant_e pick_grant(input logic if_req, input logic dm_req,
                                        input logic [SW-1:0] streak);
    grant_e g;
    g = GNT_NONE;
    if (dm_req && (!if_req || (streak < STREAK_MAX))) begin
      g = GNT_DM;
    end else if (if_req) begin
      g = GNT_IF;
    end else begin
      g = GNT_NONE;
    end
    return g;
  endfunction

  // Arbitration decision for the current IDLE cycle
  always_comb begin
    pick_s = pick_grant(bus.if_req_i, bus.dm_req_i, streak_r);
  end

  // Arbiter FSM with registered memory command, streak counter and sticky protocol error
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r     <= ST_IDLE;
      grant_r     <= GNT_NONE;
      streak_r    <= '0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      proto_err_r <= 1'b0;
    end else begin
      if (bus.mem_ack_i && (state_r == ST_IDLE)) begin
        proto_err_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          case (pick_s)
            GNT_DM: begin
              state_r     <= ST_BUSY_DM;
              grant_r     <= GNT_DM;
              mem_req_r   <= 1'b1;
              mem_we_r    <= bus.dm_we_i;
              mem_addr_r  <= bus.dm_addr_i;
              mem_wdata_r <= bus.dm_wdata_i;
              // only a data grant that actually overtakes a waiting fetch counts
              if (bus.if_req_i) begin
                streak_r <= (streak_r == STREAK_MAX) ? STREAK_MAX : (streak_r + STREAK_ONE);
              end else begin
                streak_r <= '0;
              end
            end
            GNT_IF: begin
              state_r    <= ST_BUSY_IF;
              grant_r    <= GNT_IF;
              mem_req_r  <= 1'b1;
              mem_we_r   <= 1'b0;
              mem_addr_r <= bus.if_addr_i;
              streak_r   <= '0;
            end
            default: begin
              state_r <= ST_IDLE;
            end
          endcase
        end
        ST_BUSY_IF, ST_BUSY_DM: begin
          if (bus.mem_ack_i) begin
            state_r   <= ST_IDLE;
            grant_r   <= GNT_NONE;
            mem_req_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          grant_r   <= GNT_NONE;
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign if_ack_s = (grant_r == GNT_IF) && bus.mem_ack_i;
  assign dm_ack_s = (grant_r == GNT_DM) && bus.mem_ack_i;

  assign bus.if_ack_o    = if_ack_s;
  assign bus.dm_ack_o    = dm_ack_s;
  assign bus.if_rdata_o  = bus.mem_rdata_i;
  assign bus.dm_rdata_o  = bus.mem_rdata_i;
  assign bus.mem_req_o   = mem_req_r;
  assign bus.mem_we_o    = mem_we_r;
  assign bus.mem_addr_o  = mem_addr_r;
  assign bus.mem_wdata_o = mem_wdata_r;
  assign bus.stall_o     = (bus.if_req_i & ~if_ack_s) | (bus.dm_req_i & ~dm_ack_s);
  assign bus.proto_err_o = proto_err_r;

endmodule
